// File: rtl/dragonfang_pkg.sv
// Shared types for the dragonfang vector datapath:
// result packets, merge controls and write-back scheduler states.
package dragonfang_pkg;

  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    ENABLED_8BIT_MODE,
    ENABLED_16BIT_MODE,
    ENABLED_32BIT_MODE,
    ENABLED_64BIT_MODE
  } bit_mode_t;

  typedef struct packed {
    bit_mode_t bit_mode;
    logic      vm;
    logic      vma;
    logic      vta;
  } write_back_vector_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } data_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MERGE,
    WRITE
  } wb_sched_state_t;

  // Element number that owns data bit b at the given element width.
  function automatic logic [2:0] elem_idx(
    input bit_mode_t  m,
    input logic [5:0] b
  );
    logic [2:0] r;
    r = 3'd0;
    unique case (m)
      ENABLED_8BIT_MODE:  r = b[5:3];
      ENABLED_16BIT_MODE: r = {1'b0, b[5:4]};
      ENABLED_32BIT_MODE: r = {2'b0, b[5]};
      ENABLED_64BIT_MODE: r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/write_back.sv
// Element-wise merge of a new result into the old vd value
// under the v0 mask and the mask-agnostic policy.
module write_back
  import dragonfang_pkg::*;
(
  input  write_back_vector_t vector,
  input  data_packet_t       v0,
  input  data_packet_t       vd_old,
  input  data_packet_t       vd_new,
  output data_packet_t       vd_out
);

  // A single packet carries no vl, so the tail policy and the
  // tags of v0/vd_old have nothing to act on here.
  logic unused_wb;
  assign unused_wb = ^{vector.vta, v0.tag, vd_old.tag};

  // Active elements take the new bits; masked-off ones keep
  // the old bits or go to all ones when mask-agnostic.
  always_comb begin
    vd_out     = vd_old;
    vd_out.tag = vd_new.tag;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (vector.vm ||
          v0.data[elem_idx(vector.bit_mode, 6'(i))]) begin
        vd_out.data[i] = vd_new.data[i];
      end else if (vector.vma) begin
        vd_out.data[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_back_rr_arbiter.sv
// Round-robin pick: first requester after ptr_i, wrapping,
// returned both one-hot and as an index.
module write_back_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]    idx_o,
  output logic               any_o
);

  logic [IDXW-1:0] cand;
  logic            found;

  // Scan ptr+1 .. ptr+NUM_REQ and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/write_back_scheduler.sv
// Shares one write_back merge between NUM_REQ producers:
// accept, read vd_old, merge, commit to the VRF.
module write_back_scheduler
  import dragonfang_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 5,
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_vd_addr,
  input  write_back_vector_t [NUM_REQ-1:0]    req_vector,
  input  data_packet_t [NUM_REQ-1:0]          req_vd_new,
  input  data_packet_t                        v0,
  output logic                                rf_rd_en,
  output logic [ADDR_WIDTH-1:0]               rf_rd_addr,
  input  data_packet_t                        rf_rd_data,
  output logic                                rf_wr_en,
  output logic [ADDR_WIDTH-1:0]               rf_wr_addr,
  output data_packet_t                        rf_wr_data,
  output logic                                done,
  output logic [TAG_WIDTH-1:0]                done_tag,
  output logic                                busy
);

  wb_sched_state_t       state_q;
  logic [IDXW-1:0]       ptr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  write_back_vector_t    vec_q;
  data_packet_t          new_q;

  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  data_packet_t          wr_data_q;
  logic                  done_q;
  logic [TAG_WIDTH-1:0]  done_tag_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDXW-1:0]       gidx;
  logic                  gany;
  logic                  can_accept;
  logic                  hs;
  data_packet_t          merged_d;

  write_back_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  write_back u_wb (
    .vector (vec_q),
    .v0     (v0),
    .vd_old (rf_rd_data),
    .vd_new (new_q),
    .vd_out (merged_d)
  );

  // WRITE overlaps the next accept, giving one op per 3 cycles.
  assign can_accept = (state_q == IDLE) || (state_q == WRITE);
  assign req_ready  = can_accept ? gnt : '0;
  assign hs         = can_accept && gany;

  // Scheduler FSM with registered VRF strobes and completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IDXW'(NUM_REQ - 1);
      addr_q     <= '0;
      vec_q      <= '0;
      new_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      done_tag_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, WRITE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          if (hs) begin
            addr_q    <= req_vd_addr[gidx];
            vec_q     <= req_vector[gidx];
            new_q     <= req_vd_new[gidx];
            ptr_q     <= gidx;
            rd_en_q   <= 1'b1;
            rd_addr_q <= req_vd_addr[gidx];
            state_q   <= READ;
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          rd_en_q <= 1'b0;
          state_q <= MERGE;
        end
        MERGE: begin
          wr_data_q  <= merged_d;
          wr_en_q    <= 1'b1;
          wr_addr_q  <= addr_q;
          done_q     <= 1'b1;
          done_tag_q <= new_q.tag;
          state_q    <= WRITE;
        end
      endcase
    end
  end

  assign rf_rd_en   = rd_en_q;
  assign rf_rd_addr = rd_addr_q;
  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign done       = done_q;
  assign done_tag   = done_tag_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_write_back_scheduler.sv
// Directed bench for write_back_scheduler with a small VRF
// model behind the read/write ports.
module tb_write_back_scheduler;
  import dragonfang_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [3:0]            req_valid;
  logic [3:0]            req_ready;
  logic [3:0][4:0]       req_vd_addr;
  write_back_vector_t [3:0] req_vector;
  data_packet_t [3:0]    req_vd_new;
  data_packet_t          v0;
  logic                  rf_rd_en;
  logic [4:0]            rf_rd_addr;
  data_packet_t          rf_rd_data;
  logic                  rf_wr_en;
  logic [4:0]            rf_wr_addr;
  data_packet_t          rf_wr_data;
  logic                  done;
  logic [TAG_WIDTH-1:0]  done_tag;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  write_back_scheduler #(
    .NUM_REQ    (4),
    .ADDR_WIDTH (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vd_addr (req_vd_addr),
    .req_vector  (req_vector),
    .req_vd_new  (req_vd_new),
    .v0          (v0),
    .rf_rd_en    (rf_rd_en),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .done        (done),
    .done_tag    (done_tag),
    .busy        (busy)
  );

  // VRF model: one-cycle read latency, bench preload port.
  data_packet_t vrf [32];
  data_packet_t rd_q;
  logic         pre_en;
  logic [4:0]   pre_addr;
  data_packet_t pre_data;

  always @(posedge clock) begin
    if (pre_en) vrf[pre_addr] <= pre_data;
    else if (rf_wr_en) vrf[rf_wr_addr] <= rf_wr_data;
    if (rf_rd_en) rd_q <= vrf[rf_rd_addr];
  end

  assign v0         = vrf[0];
  assign rf_rd_data = rd_q;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [63:0] d);
    pre_addr = a;
    pre_data = '{tag: '0, data: d};
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] ref_wb(
    input bit_mode_t m, input logic vm, input logic vma,
    input logic [63:0] v0d, input logic [63:0] old,
    input logic [63:0] nw);
    int sew;
    logic [63:0] r;
    sew = 8 << int'(m);
    r   = old;
    for (int e = 0; e < 64 / sew; e++) begin
      for (int b = 0; b < sew; b++) begin
        if (vm || v0d[e]) r[e*sew+b] = nw[e*sew+b];
        else if (vma) r[e*sew+b] = 1'b1;
      end
    end
    return r;
  endfunction

  // One complete op on an idle scheduler, checked cycle by cycle.
  task automatic op(input logic [1:0] i, input logic [4:0] a,
                    input write_back_vector_t vec,
                    input data_packet_t pk,
                    input logic [63:0] exp, input string nm);
    int w;
    logic [63:0] g;
    w = 0;
    req_vd_addr[i] = a;
    req_vector[i]  = vec;
    req_vd_new[i]  = pk;
    req_valid[i]   = 1'b1;
    #1;
    while (req_ready[i] !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    g = 64'd1 << i;
    chk({nm, " grant"}, 64'(req_ready), g);
    tick();
    req_valid[i] = 1'b0;
    chk({nm, " rd"}, 64'({rf_rd_en, rf_rd_addr}), 64'({1'b1, a}));
    tick();
    chk({nm, " merge strobes"}, 64'({rf_rd_en, rf_wr_en, done}), 64'd0);
    tick();
    chk({nm, " wr"}, 64'({rf_wr_en, done, rf_rd_en, rf_wr_addr}),
        64'({1'b1, 1'b1, 1'b0, a}));
    chk({nm, " data"}, rf_wr_data.data, exp);
    chk({nm, " tag"}, 64'(done_tag), 64'(pk.tag));
    tick();
  endtask

  typedef struct {
    bit_mode_t   mode;
    logic        vm;
    logic        vma;
    logic [63:0] v0d;
    logic [63:0] old;
    logic [63:0] nw;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    write_back_vector_t vec;
    data_packet_t       pk;
    int                 g [$];
    int                 gc [$];
    int                 cyc;
    int                 idx;
    logic               seen;
    logic [63:0]        o, n, e;

    tbl[0] = '{ENABLED_8BIT_MODE, 1'b0, 1'b0, 64'h55, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_00FF_00FF_00FF};
    tbl[1] = '{ENABLED_8BIT_MODE, 1'b0, 1'b1, 64'h0F,
               64'h1234_5678_9ABC_DEF0, 64'h0,
               64'hFFFF_FFFF_0000_0000};
    tbl[2] = '{ENABLED_16BIT_MODE, 1'b0, 1'b0, 64'h05,
               64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD,
               64'h1111_BBBB_3333_DDDD};
    tbl[3] = '{ENABLED_32BIT_MODE, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h5555_5555_5555_5555,
               64'h0123_4567_89AB_CDEF, 64'h0123_4567_FFFF_FFFF};
    tbl[4] = '{ENABLED_64BIT_MODE, 1'b0, 1'b0, 64'h0,
               64'hCAFE_F00D_0000_1234, 64'h9999_9999_9999_9999,
               64'hCAFE_F00D_0000_1234};
    tbl[5] = '{ENABLED_64BIT_MODE, 1'b0, 1'b0, 64'h1,
               64'hCAFE_F00D_0000_1234, 64'h9999_9999_9999_9999,
               64'h9999_9999_9999_9999};
    tbl[6] = '{ENABLED_8BIT_MODE, 1'b1, 1'b1, 64'h0,
               64'h7777_7777_7777_7777, 64'h0102_0304_0506_0708,
               64'h0102_0304_0506_0708};

    reset       = 1'b1;
    req_valid   = '0;
    req_vd_addr = '0;
    req_vector  = '0;
    req_vd_new  = '0;
    pre_en      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;

    // 1: reset state
    tick();
    tick();
    chk("reset outs", 64'({req_ready, rf_rd_en, rf_wr_en, done, busy}),
        64'd0);
    reset = 1'b0;
    tick();
    chk("post reset outs",
        64'({req_ready, rf_rd_en, rf_wr_en, done, busy}), 64'd0);

    // 2: single op from requester 2
    vec = '{bit_mode: ENABLED_64BIT_MODE, vm: 1'b1, vma: 1'b0,
            vta: 1'b0};
    pk  = '{tag: 6'd5, data: 64'hDEAD_BEEF_0123_4567};
    op(2'd2, 5'd7, vec, pk, 64'hDEAD_BEEF_0123_4567, "single");

    // hand-computed merge vectors
    for (int k = 0; k < 7; k++) begin
      preload(5'd0, tbl[k].v0d);
      preload(5'(8 + k), tbl[k].old);
      vec = '{bit_mode: tbl[k].mode, vm: tbl[k].vm,
              vma: tbl[k].vma, vta: 1'b0};
      pk  = '{tag: 6'(k + 1), data: tbl[k].nw};
      op(2'(k & 3), 5'(8 + k), vec, pk, tbl[k].exp,
         $sformatf("vec%0d", k));
    end

    // 3: round-robin order with all requesters valid
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_vd_addr[k] = 5'(20 + k);
      req_vector[k]  = '{bit_mode: ENABLED_64BIT_MODE, vm: 1'b1,
                         vma: 1'b0, vta: 1'b0};
      req_vd_new[k]  = '{tag: 6'(k), data: 64'(k)};
    end
    req_valid = 4'b1111;
    #1;
    cyc = 0;
    while (g.size() < 5 && cyc < 40) begin
      if (req_ready != 4'b0000) begin
        idx = -1;
        for (int k = 0; k < 4; k++) if (req_ready[k]) idx = k;
        chk("rr onehot", 64'($countones(req_ready)), 64'd1);
        g.push_back(idx);
        gc.push_back(cyc);
        if (g.size() == 5) req_valid = '0;
      end
      if (g.size() < 5) begin
        tick();
        cyc++;
      end
    end
    chk("rr grants", 64'(g.size()), 64'd5);
    for (int k = 0; k < g.size(); k++) begin
      chk($sformatf("rr order %0d", k), 64'(g[k]), 64'(k % 4));
      if (k > 0)
        chk($sformatf("rr gap %0d", k), 64'(gc[k] - gc[k-1]), 64'd3);
    end
    tick();
    tick();
    chk("rr drained", 64'(busy), 64'd0);

    // 4: back-to-back ops to the same vd
    preload(5'd0, 64'h0);
    preload(5'd3, 64'h0);
    req_vd_addr[0] = 5'd3;
    req_vector[0]  = '{bit_mode: ENABLED_64BIT_MODE, vm: 1'b1,
                       vma: 1'b0, vta: 1'b0};
    req_vd_new[0]  = '{tag: 6'd1, data: 64'h1111_1111_1111_1111};
    req_valid[0]   = 1'b1;
    #1;
    chk("raw req0 grant", 64'(req_ready), 64'h1);
    tick();
    req_valid[0]   = 1'b0;
    req_vd_addr[1] = 5'd3;
    req_vector[1]  = '{bit_mode: ENABLED_8BIT_MODE, vm: 1'b0,
                       vma: 1'b0, vta: 1'b0};
    req_vd_new[1]  = '{tag: 6'd2, data: 64'h2222_2222_2222_2222};
    req_valid[1]   = 1'b1;
    #1;
    chk("raw req0 rd", 64'({rf_rd_en, req_ready}), 64'h10);
    tick();
    chk("raw merge ready", 64'(req_ready), 64'h0);
    tick();
    chk("raw req0 wr", 64'({rf_wr_en, rf_wr_addr}), 64'({1'b1, 5'd3}));
    chk("raw req0 data", rf_wr_data.data, 64'h1111_1111_1111_1111);
    chk("raw req1 grant", 64'(req_ready), 64'h2);
    tick();
    req_valid[1] = 1'b0;
    chk("raw req1 rd", 64'({rf_rd_en, rf_wr_en, rf_rd_addr}),
        64'({1'b1, 1'b0, 5'd3}));
    tick();
    chk("raw vd_old", rf_rd_data.data, 64'h1111_1111_1111_1111);
    tick();
    chk("raw req1 wr", 64'({rf_wr_en, done, done_tag}),
        64'({1'b1, 1'b1, 6'd2}));
    chk("raw req1 data", rf_wr_data.data, 64'h1111_1111_1111_1111);
    tick();

    // 5: reset while in MERGE
    req_vd_addr[2] = 5'd9;
    req_vd_new[2]  = '{tag: 6'd9, data: 64'hABCD};
    req_vector[2]  = '{bit_mode: ENABLED_64BIT_MODE, vm: 1'b1,
                       vma: 1'b0, vta: 1'b0};
    req_valid[2]   = 1'b1;
    #1;
    chk("rst grant", 64'(req_ready), 64'h4);
    tick();
    req_valid[2] = 1'b0;
    tick();
    chk("rst in merge", 64'({busy, rf_rd_en, rf_wr_en}), 64'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rf_wr_en || done || busy) seen = 1'b1;
      tick();
    end
    chk("rst dropped op", 64'(seen), 64'd0);
    req_valid = 4'b1001;
    #1;
    chk("rst next grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    // 6: 8-bit masked merge against the reference model
    preload(5'd0, 64'h0000_0000_0000_00A5);
    for (int k = 0; k < 4; k++) begin
      o = {$urandom(), $urandom()};
      n = {$urandom(), $urandom()};
      preload(5'd12, o);
      vec = '{bit_mode: ENABLED_8BIT_MODE, vm: 1'b0,
              vma: k[0], vta: 1'b0};
      pk  = '{tag: 6'(40 + k), data: n};
      e   = ref_wb(ENABLED_8BIT_MODE, 1'b0, k[0], 64'hA5, o, n);
      op(2'(3 - k), 5'd12, vec, pk, e, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
